// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder controller.
// Holds the state encoding and a helper for sizing the nibble index.
package nibble_serial_adder_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Index register width for n nibbles; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_full_adder_4bit.sv
// Four-bit ripple-carry adder slice shared by the nibble-serial controller.
// Purely combinational: sum = x + y + c_in, with carry out of bit 3.
module full_adder_4bit (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out
);

    logic [4:0] carry;

    assign carry[0] = c_in;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign sum[i]     = x[i] ^ y[i] ^ carry[i];
        assign carry[i+1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
    end

    assign c_out = carry[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle add/subtract controller: feeds one 4-bit adder slice a nibble per
// clock, LSB first, with the inter-nibble carry held in a register.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int unsigned NIB   = WIDTH / NIBBLE_W;
    localparam int unsigned IDX_W = idx_width(NIB);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
    end

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic [IDX_W-1:0] idx_q;
    logic             busy_q;
    logic             done_q;
    logic             c_out_q;
    logic             ovf_q;

    logic [3:0]       nib_x;
    logic [3:0]       nib_y;
    logic [3:0]       nib_sum;
    logic             nib_c;
    logic             accept;

    // Current nibble of each latched operand presented to the shared slice.
    assign nib_x = a_q[NIBBLE_W*idx_q +: NIBBLE_W];
    assign nib_y = b_q[NIBBLE_W*idx_q +: NIBBLE_W];

    full_adder_4bit u_slice (
        .x     (nib_x),
        .y     (nib_y),
        .c_in  (carry_q),
        .sum   (nib_sum),
        .c_out (nib_c)
    );

    assign accept = start && (state != ST_RUN);

    // Sequencer: operand capture, per-nibble accumulation and result flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        // Subtraction is a + ~b + 1: invert B and seed the carry.
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub;
                        idx_q   <= '0;
                        sum_q   <= '0;
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state   <= ST_RUN;
                    end else begin
                        state   <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    sum_q[NIBBLE_W*idx_q +: NIBBLE_W] <= nib_sum;
                    carry_q <= nib_c;
                    if (idx_q == IDX_LAST) begin
                        state   <= ST_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        c_out_q <= nib_c;
                        ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                   (nib_sum[3] != a_q[WIDTH-1]);
                        idx_q   <= '0;
                    end else begin
                        idx_q   <= idx_q + IDX_W'(1);
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sum      = sum_q;
    assign c_out    = c_out_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder at WIDTH=16.
module tb_nibble_serial_adder;

    localparam int unsigned WIDTH = 16;

    logic             clk;
    logic             reset;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             overflow;

    int n_checks = 0;
    int n_fail   = 0;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .c_out    (c_out),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a request and let the accepting edge pass; start drops afterwards.
    task automatic issue(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                         input logic vsub);
        a = va; b = vb; sub = vsub; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Count edges until done rises; 0 means it never did within the budget.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        tick();
        tick();
        n_checks++;
        if ({busy, done, sum, c_out, overflow} !== {1'b0, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b done=%b sum=%h c=%b ovf=%b, expected all 0",
                     busy, done, sum, c_out, overflow);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_add_basic();
        int lat;
        issue(16'h1234, 16'h4321, 1'b0);
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL add_basic_busy: busy=%b done=%b, expected 1 0", busy, done);
        end
        wait_done(lat);
        n_checks++;
        if (lat != 4) begin
            n_fail++;
            $display("FAIL add_basic_latency: %0d edges, expected 4", lat);
        end
        n_checks++;
        if (sum !== 16'h5555 || c_out !== 1'b0 || overflow !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL add_basic_result: sum=%h c=%b ovf=%b busy=%b, expected 5555 0 0 0",
                     sum, c_out, overflow, busy);
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || sum !== 16'h5555) begin
            n_fail++;
            $display("FAIL add_basic_pulse: done=%b sum=%h, expected 0 5555", done, sum);
        end
        tick();
    endtask

    task automatic test_carry_chain();
        int lat;
        issue(16'hFFFF, 16'h0001, 1'b0);
        wait_done(lat);
        n_checks++;
        if (lat != 4 || sum !== 16'h0000 || c_out !== 1'b1 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL carry_chain: lat=%0d sum=%h c=%b ovf=%b, expected 4 0000 1 0",
                     lat, sum, c_out, overflow);
        end
        tick();
    endtask

    task automatic test_overflow_sub();
        int lat;
        issue(16'h7FFF, 16'h0001, 1'b0);
        wait_done(lat);
        n_checks++;
        if (lat != 4 || sum !== 16'h8000 || c_out !== 1'b0 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL add_overflow: lat=%0d sum=%h c=%b ovf=%b, expected 4 8000 0 1",
                     lat, sum, c_out, overflow);
        end
        tick();
        issue(16'h0005, 16'h0007, 1'b1);
        n_checks++;
        if (sum !== 16'h0000 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL accept_clears: sum=%h ovf=%b, expected 0000 0", sum, overflow);
        end
        wait_done(lat);
        n_checks++;
        if (lat != 4 || sum !== 16'hFFFE || c_out !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_borrow: lat=%0d sum=%h c=%b ovf=%b, expected 4 fffe 0 0",
                     lat, sum, c_out, overflow);
        end
        tick();
    endtask

    task automatic test_start_while_busy();
        int lat;
        issue(16'h1111, 16'h2222, 1'b0);
        tick();
        a = 16'hAAAA; b = 16'h5555; sub = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 2;
        for (int i = 3; i <= 12; i++) begin
            if (done === 1'b1) break;
            tick();
            lat = i;
        end
        n_checks++;
        if (lat != 4 || sum !== 16'h3333 || c_out !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL start_ignored: lat=%0d sum=%h c=%b ovf=%b, expected 4 3333 0 0",
                     lat, sum, c_out, overflow);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL start_ignored_idle: busy=%b done=%b, expected 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        issue(16'h1234, 16'h4321, 1'b0);
        tick();
        tick();
        n_checks++;
        if (busy !== 1'b1 || sum === 16'h0000) begin
            n_fail++;
            $display("FAIL mid_run_partial: busy=%b sum=%h, expected busy 1 and partial sum", busy, sum);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, sum, c_out, overflow} !== {1'b0, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset: busy=%b done=%b sum=%h c=%b ovf=%b, expected all 0",
                     busy, done, sum, c_out, overflow);
        end
        tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_discard: busy=%b done=%b, expected 0 0", busy, done);
        end
        issue(16'h0F0F, 16'h0101, 1'b0);
        wait_done(lat);
        n_checks++;
        if (lat != 4 || sum !== 16'h1010 || c_out !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset_op: lat=%0d sum=%h c=%b ovf=%b, expected 4 1010 0 0",
                     lat, sum, c_out, overflow);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat;
        a = 16'h0001; b = 16'h0002; sub = 1'b0; start = 1'b1;
        tick();
        wait_done(lat);
        n_checks++;
        if (lat != 4 || sum !== 16'h0003 || c_out !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_first: lat=%0d sum=%h c=%b, expected 4 0003 0", lat, sum, c_out);
        end
        a = 16'h8000; b = 16'h0001; sub = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0 || sum !== 16'h0000) begin
            n_fail++;
            $display("FAIL b2b_accept: busy=%b done=%b sum=%h, expected 1 0 0000", busy, done, sum);
        end
        wait_done(lat);
        n_checks++;
        if (lat != 4 || sum !== 16'h7FFF || c_out !== 1'b1 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second: lat=%0d (period %0d) sum=%h c=%b ovf=%b, expected 4 (5) 7fff 1 1",
                     lat, lat + 1, sum, c_out, overflow);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_carry_chain();
        test_overflow_sub();
        test_start_while_busy();
        test_reset_mid_run();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
